// File: rtl/vram_banked_arb.sv
// vram_banked_arb
//   Banked video RAM shared between the video fetch pipeline and the host CPU.
//   Each of the BANKS banks is a single-port, 1-cycle-latency word memory.
//   Video reads have priority on their bank. A host request that keeps losing
//   the same bank for HOST_MAX_WAIT cycles takes the next slot from video.
// Ports
//   clk, reset_n                       clock, asynchronous active-low reset
//   vid_en / vid_address               per-bank video read requests (packed per bank)
//   vid_read_data / vid_read_valid     per-bank video read results, 1 cycle later
//   host_valid / host_ready            host handshake (ready is combinational)
//   host_write / host_bank / host_address / host_write_data / host_byte_en
//                                      host request fields
//   host_read_data / host_read_valid   host read result, 1 cycle after accept
//   host_starved                       1-cycle pulse when an override took a video slot
module vram_banked_arb #(
    parameter int BANKS         = 2,
    parameter int ADDR_BITS     = 14,
    parameter int DATA_BITS     = 16,
    parameter int HOST_MAX_WAIT = 8,
    localparam int BANK_BITS    = (BANKS > 1) ? $clog2(BANKS) : 1,
    localparam int BE_BITS      = DATA_BITS / 8
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [BANKS-1:0]               vid_en,
    input  logic [BANKS*ADDR_BITS-1:0]     vid_address,
    output logic [BANKS*DATA_BITS-1:0]     vid_read_data,
    output logic [BANKS-1:0]               vid_read_valid,
    input  logic                           host_valid,
    input  logic                           host_write,
    input  logic [BANK_BITS-1:0]           host_bank,
    input  logic [ADDR_BITS-1:0]           host_address,
    input  logic [DATA_BITS-1:0]           host_write_data,
    input  logic [BE_BITS-1:0]             host_byte_en,
    output logic                           host_ready,
    output logic [DATA_BITS-1:0]           host_read_data,
    output logic                           host_read_valid,
    output logic                           host_starved
);

    localparam int WAIT_BITS = (HOST_MAX_WAIT > 0) ? $clog2(HOST_MAX_WAIT + 1) : 1;
    localparam logic [WAIT_BITS-1:0] WAIT_MAX = WAIT_BITS'(HOST_MAX_WAIT);
    localparam int DEPTH = 2 ** ADDR_BITS;

    logic                                host_req_s;
    logic                                host_oor_s;
    logic                                override_s;
    logic                                vid_conflict_s;
    logic                                host_ready_s;
    logic [BANKS-1:0]                    host_own_s;
    logic [BANKS-1:0]                    vid_own_s;
    logic [BANKS-1:0][ADDR_BITS-1:0]     bank_addr_s;
    logic [BANKS-1:0][DATA_BITS-1:0]     bank_q_s;
    logic [DATA_BITS-1:0]                host_src_s;

    logic [WAIT_BITS-1:0]                wait_cnt_r;
    logic [BANKS-1:0]                    vid_read_valid_r;
    logic [BANKS-1:0][DATA_BITS-1:0]     vid_hold_r;
    logic                                host_read_valid_r;
    logic [DATA_BITS-1:0]                host_hold_r;
    logic [BANK_BITS-1:0]                host_bank_r;
    logic                                host_oor_r;
    logic                                host_starved_r;

    // Host request is masked while in reset so nothing is accepted or written.
    assign host_req_s = host_valid && reset_n;
    // Banks that do not exist (non power-of-two BANKS) are served with no conflict.
    assign host_oor_s = ({1'b0, host_bank} >= (BANK_BITS + 1)'(BANKS));
    assign override_s = (HOST_MAX_WAIT != 0) && (wait_cnt_r == WAIT_MAX) && host_req_s;

    // Per-bank ownership and address select; video wins unless overridden.
    always_comb begin
        host_own_s     = '0;
        vid_own_s      = '0;
        bank_addr_s    = '0;
        vid_conflict_s = 1'b0;
        for (int b = 0; b < BANKS; b++) begin
            if (host_bank == BANK_BITS'(b)) begin
                vid_conflict_s = vid_en[b];
            end else begin
                vid_conflict_s = vid_conflict_s;
            end
            if (host_req_s && !host_oor_s && (host_bank == BANK_BITS'(b)) &&
                (!vid_en[b] || override_s)) begin
                host_own_s[b] = 1'b1;
            end else begin
                host_own_s[b] = 1'b0;
            end
            vid_own_s[b] = vid_en[b] && !host_own_s[b];
            if (host_own_s[b]) begin
                bank_addr_s[b] = host_address;
            end else begin
                bank_addr_s[b] = vid_address[b*ADDR_BITS +: ADDR_BITS];
            end
        end
    end

    assign host_ready_s = host_req_s && (host_oor_s || (|host_own_s));
    assign host_ready   = host_ready_s;

    // One single-port array per bank; read data lands in the bank's output register.
    for (genvar g = 0; g < BANKS; g++) begin : g_bank
        logic [DATA_BITS-1:0] mem_r [DEPTH];
        logic [DATA_BITS-1:0] rd_q_r;

        // Byte-masked host write and shared-port read, no reset on storage.
        always_ff @(posedge clk) begin
            if (host_own_s[g] && host_write) begin
                for (int i = 0; i < BE_BITS; i++) begin
                    if (host_byte_en[i]) begin
                        mem_r[bank_addr_s[g]][i*8 +: 8] <= host_write_data[i*8 +: 8];
                    end
                end
            end
            if (host_own_s[g] || vid_own_s[g]) begin
                rd_q_r <= mem_r[bank_addr_s[g]];
            end
        end

        assign bank_q_s[g] = rd_q_r;
        // Fresh data on the valid cycle, otherwise the last delivered word.
        assign vid_read_data[g*DATA_BITS +: DATA_BITS] =
            vid_read_valid_r[g] ? bank_q_s[g] : vid_hold_r[g];
    end

    // Pick the bank register the last accepted host read went to.
    always_comb begin
        host_src_s = '0;
        if (!host_oor_r) begin
            for (int b = 0; b < BANKS; b++) begin
                if (host_bank_r == BANK_BITS'(b)) begin
                    host_src_s = bank_q_s[b];
                end else begin
                    host_src_s = host_src_s;
                end
            end
        end else begin
            host_src_s = '0;
        end
    end

    // Host stall counter, saturating; any accept or idle cycle restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_r <= '0;
        end else if (!host_req_s || host_ready_s) begin
            wait_cnt_r <= '0;
        end else if (wait_cnt_r != WAIT_MAX) begin
            wait_cnt_r <= wait_cnt_r + 1'b1;
        end
    end

    // Read-valid pipeline, starvation pulse and held output data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid_read_valid_r  <= '0;
            vid_hold_r        <= '0;
            host_read_valid_r <= 1'b0;
            host_hold_r       <= '0;
            host_bank_r       <= '0;
            host_oor_r        <= 1'b0;
            host_starved_r    <= 1'b0;
        end else begin
            vid_read_valid_r  <= vid_own_s;
            host_read_valid_r <= host_ready_s && !host_write;
            host_starved_r    <= override_s && vid_conflict_s;
            for (int b = 0; b < BANKS; b++) begin
                if (vid_read_valid_r[b]) begin
                    vid_hold_r[b] <= bank_q_s[b];
                end
            end
            if (host_read_valid_r) begin
                host_hold_r <= host_src_s;
            end
            if (host_ready_s && !host_write) begin
                host_bank_r <= host_bank;
                host_oor_r  <= host_oor_s;
            end
        end
    end

    assign vid_read_valid  = vid_read_valid_r;
    assign host_read_valid = host_read_valid_r;
    assign host_read_data  = host_read_valid_r ? host_src_s : host_hold_r;
    assign host_starved    = host_starved_r;

endmodule

// File: tb/tb_vram_banked_arb.sv
// tb_vram_banked_arb
//   Directed table of single-cycle transactions followed by hand-written
//   sequences for bank conflict, the disabled override and reset behaviour.
//   dut uses HOST_MAX_WAIT=8, dut_z uses HOST_MAX_WAIT=0; both share inputs.
module tb_vram_banked_arb;

    logic        clk;
    logic        reset_n;
    logic [1:0]  vid_en;
    logic [27:0] vid_address;
    logic        host_valid;
    logic        host_write;
    logic        host_bank;
    logic [13:0] host_address;
    logic [15:0] host_write_data;
    logic [1:0]  host_byte_en;

    logic [31:0] vid_read_data,  vid_read_data_z;
    logic [1:0]  vid_read_valid, vid_read_valid_z;
    logic        host_ready,     host_ready_z;
    logic [15:0] host_read_data, host_read_data_z;
    logic        host_read_valid, host_read_valid_z;
    logic        host_starved,   host_starved_z;

    int checks = 0;
    int errors = 0;

    vram_banked_arb #(.BANKS(2), .ADDR_BITS(14), .DATA_BITS(16), .HOST_MAX_WAIT(8)) dut (
        .clk(clk), .reset_n(reset_n), .vid_en(vid_en), .vid_address(vid_address),
        .vid_read_data(vid_read_data), .vid_read_valid(vid_read_valid),
        .host_valid(host_valid), .host_write(host_write), .host_bank(host_bank),
        .host_address(host_address), .host_write_data(host_write_data),
        .host_byte_en(host_byte_en), .host_ready(host_ready),
        .host_read_data(host_read_data), .host_read_valid(host_read_valid),
        .host_starved(host_starved)
    );

    vram_banked_arb #(.BANKS(2), .ADDR_BITS(14), .DATA_BITS(16), .HOST_MAX_WAIT(0)) dut_z (
        .clk(clk), .reset_n(reset_n), .vid_en(vid_en), .vid_address(vid_address),
        .vid_read_data(vid_read_data_z), .vid_read_valid(vid_read_valid_z),
        .host_valid(host_valid), .host_write(host_write), .host_bank(host_bank),
        .host_address(host_address), .host_write_data(host_write_data),
        .host_byte_en(host_byte_en), .host_ready(host_ready_z),
        .host_read_data(host_read_data_z), .host_read_valid(host_read_valid_z),
        .host_starved(host_starved_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  vid_en;
        logic [13:0] va0;
        logic [13:0] va1;
        logic        hv;
        logic        hw;
        logic        hb;
        logic [13:0] ha;
        logic [15:0] wd;
        logic [1:0]  be;
        logic        exp_ready;
        logic [1:0]  exp_vv;
        logic [15:0] exp_vd0;
        logic [15:0] exp_vd1;
        logic        exp_hrv;
        logic [15:0] exp_hrd;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] ve, input logic [13:0] a0, input logic [13:0] a1,
                         input logic hv, input logic hw, input logic hb,
                         input logic [13:0] ha, input logic [15:0] wd, input logic [1:0] be);
        vid_en          = ve;
        vid_address     = {a1, a0};
        host_valid      = hv;
        host_write      = hw;
        host_bank       = hb;
        host_address    = ha;
        host_write_data = wd;
        host_byte_en    = be;
    endtask

    // Host read of bank0 addr 0 against continuous video on bank0: 8 stalls, then override.
    task automatic conflict_run(input string tag);
        drive(2'b01, 14'h0000, 14'h0000, 1'b1, 1'b0, 1'b0, 14'h0000, 16'h0000, 2'b00);
        for (int k = 0; k <= 8; k++) begin
            #1;
            chk({tag, "_ready"}, {31'd0, host_ready}, {31'd0, (k == 8)});
            @(posedge clk);
            #1;
            chk({tag, "_vvalid0"}, {31'd0, vid_read_valid[0]}, {31'd0, (k != 8)});
            chk({tag, "_starved"}, {31'd0, host_starved}, {31'd0, (k == 8)});
        end
        chk({tag, "_hrvalid"}, {31'd0, host_read_valid}, 32'd1);
        chk({tag, "_hrdata"}, {16'd0, host_read_data}, 32'h0000A5A5);
        host_valid = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_starved_end"}, {31'd0, host_starved}, 32'd0);
        chk({tag, "_vvalid0_end"}, {31'd0, vid_read_valid[0]}, 32'd1);
    endtask

    initial begin
        bit bad_ready;
        bit bad_starved;

        vecs[0]  = '{2'b00, 14'h0000, 14'h0000, 1'b1, 1'b1, 1'b1, 14'h0123, 16'hBEEF, 2'b11,
                     1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        vecs[1]  = '{2'b00, 14'h0000, 14'h0000, 1'b1, 1'b0, 1'b1, 14'h0123, 16'h0000, 2'b00,
                     1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 16'hBEEF};
        vecs[2]  = '{2'b00, 14'h0000, 14'h0000, 1'b1, 1'b1, 1'b1, 14'h0123, 16'h1234, 2'b01,
                     1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'hBEEF};
        vecs[3]  = '{2'b00, 14'h0000, 14'h0000, 1'b1, 1'b0, 1'b1, 14'h0123, 16'h0000, 2'b00,
                     1'b1, 2'b00, 16'h0000, 16'h0000, 1'b1, 16'hBE34};
        vecs[4]  = '{2'b00, 14'h0000, 14'h0000, 1'b1, 1'b1, 1'b0, 14'h0000, 16'hA5A5, 2'b11,
                     1'b1, 2'b00, 16'h0000, 16'h0000, 1'b0, 16'hBE34};
        vecs[5]  = '{2'b01, 14'h0000, 14'h0000, 1'b1, 1'b0, 1'b1, 14'h0123, 16'h0000, 2'b00,
                     1'b1, 2'b01, 16'hA5A5, 16'h0000, 1'b1, 16'hBE34};
        vecs[6]  = '{2'b11, 14'h0000, 14'h0123, 1'b0, 1'b0, 1'b0, 14'h0000, 16'h0000, 2'b00,
                     1'b0, 2'b11, 16'hA5A5, 16'hBE34, 1'b0, 16'hBE34};
        vecs[7]  = '{2'b00, 14'h0000, 14'h0000, 1'b0, 1'b0, 1'b0, 14'h0000, 16'h0000, 2'b00,
                     1'b0, 2'b00, 16'hA5A5, 16'hBE34, 1'b0, 16'hBE34};
        vecs[8]  = '{2'b00, 14'h0000, 14'h0000, 1'b1, 1'b1, 1'b1, 14'h0002, 16'hC3C3, 2'b11,
                     1'b1, 2'b00, 16'hA5A5, 16'hBE34, 1'b0, 16'hBE34};
        vecs[9]  = '{2'b10, 14'h0000, 14'h0002, 1'b1, 1'b0, 1'b0, 14'h0000, 16'h0000, 2'b00,
                     1'b1, 2'b10, 16'hA5A5, 16'hC3C3, 1'b1, 16'hA5A5};
        vecs[10] = '{2'b00, 14'h0000, 14'h0000, 1'b0, 1'b0, 1'b0, 14'h0000, 16'h0000, 2'b00,
                     1'b0, 2'b00, 16'hA5A5, 16'hC3C3, 1'b0, 16'hA5A5};

        reset_n = 1'b0;
        drive(2'b00, 14'h0000, 14'h0000, 1'b0, 1'b0, 1'b0, 14'h0000, 16'h0000, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", {28'd0, host_ready, vid_read_valid, host_read_valid},
            32'd0);
        chk("reset_data", vid_read_data | {16'd0, host_read_data}, 32'd0);
        chk("reset_starved", {30'd0, host_starved, host_starved_z}, 32'd0);
        chk("reset_z_ctrl", {28'd0, host_ready_z, vid_read_valid_z, host_read_valid_z}, 32'd0);
        reset_n = 1'b1;

        // Single-cycle transactions: ready sampled before the edge, results after.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].vid_en, vecs[i].va0, vecs[i].va1, vecs[i].hv, vecs[i].hw,
                  vecs[i].hb, vecs[i].ha, vecs[i].wd, vecs[i].be);
            #1;
            chk($sformatf("v%0d_ready", i), {31'd0, host_ready}, {31'd0, vecs[i].exp_ready});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_vvalid", i), {30'd0, vid_read_valid}, {30'd0, vecs[i].exp_vv});
            chk($sformatf("v%0d_vdata", i), vid_read_data, {vecs[i].exp_vd1, vecs[i].exp_vd0});
            chk($sformatf("v%0d_hrvalid", i), {31'd0, host_read_valid}, {31'd0, vecs[i].exp_hrv});
            chk($sformatf("v%0d_hrdata", i), {16'd0, host_read_data}, {16'd0, vecs[i].exp_hrd});
            chk($sformatf("v%0d_starved", i), {31'd0, host_starved}, 32'd0);
        end

        // Bank conflict resolved by the anti-starvation override.
        conflict_run("t3");

        // Override disabled: host waits as long as video keeps the bank.
        bad_ready   = 1'b0;
        bad_starved = 1'b0;
        drive(2'b01, 14'h0000, 14'h0000, 1'b1, 1'b0, 1'b0, 14'h0000, 16'h0000, 2'b00);
        for (int k = 0; k < 100; k++) begin
            #1;
            if (host_ready_z) bad_ready = 1'b1;
            @(posedge clk);
            #1;
            if (host_starved_z) bad_starved = 1'b1;
        end
        chk("t5_never_ready", {31'd0, bad_ready}, 32'd0);
        chk("t5_never_starved", {31'd0, bad_starved}, 32'd0);
        vid_en = 2'b00;
        #1;
        chk("t5_ready_free", {31'd0, host_ready_z}, 32'd1);
        @(posedge clk);
        #1;
        chk("t5_hrvalid", {31'd0, host_read_valid_z}, 32'd1);
        chk("t5_hrdata", {16'd0, host_read_data_z}, 32'h0000A5A5);
        host_valid = 1'b0;
        @(posedge clk);
        #1;

        // Reset lands while a host read is being accepted.
        drive(2'b00, 14'h0000, 14'h0000, 1'b1, 1'b0, 1'b1, 14'h0123, 16'h0000, 2'b00);
        #1;
        chk("t6_ready", {31'd0, host_ready}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_async_ctrl", {27'd0, host_ready, vid_read_valid, host_read_valid, host_starved},
            32'd0);
        chk("t6_async_data", vid_read_data | {16'd0, host_read_data}, 32'd0);
        @(posedge clk);
        #1;
        chk("t6_hrvalid_dropped", {31'd0, host_read_valid}, 32'd0);
        host_valid = 1'b0;
        reset_n    = 1'b1;
        host_valid = 1'b1;
        #1;
        chk("t6_ready_after", {31'd0, host_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("t6_hrvalid_after", {31'd0, host_read_valid}, 32'd1);
        chk("t6_retained", {16'd0, host_read_data}, 32'h0000BE34);
        host_valid = 1'b0;
        @(posedge clk);
        #1;

        // Partially waited request, then reset: the wait restarts from zero.
        drive(2'b01, 14'h0000, 14'h0000, 1'b1, 1'b0, 1'b0, 14'h0000, 16'h0000, 2'b00);
        repeat (4) @(posedge clk);
        #1;
        chk("t6b_stalled", {31'd0, host_ready}, 32'd0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        conflict_run("t6b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
